// File: rtl/interrupt_ack_sequencer_8259a.sv
// 8259A control sequencer: priority resolution, 8086-mode INTA handshake, ISR and EOI handling.
// Optional auto-EOI support is compiled in with INTERRUPT_ACK_SEQUENCER_AUTO_EOI_EN.
module interrupt_ack_sequencer_8259a (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [4:0] vector_base,
  input  logic       interrupt_acknowledge_n,
  input  logic       eoi_pulse,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  input  logic       auto_eoi_config,
  output logic       interrupt_to_cpu,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK1  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_ACK2  = 3'd4
  } state_t;

  state_t     state_r;
  logic [2:0] lowest_priority_r;
  logic       inta_prev_r;

  logic [3:0] cand_s;
  logic [3:0] top_s;
  logic       qualify_s;
  logic       fall_s;
  logic       rise_s;
  logic       first_ack_s;
  logic       final_ack_s;
  logic       auto_eoi_s;
  logic       eoi_hit_s;
  logic [2:0] eoi_lvl_s;
  logic [2:0] ack_level_s;
  logic [7:0] isr_clr_s;
  logic [7:0] isr_set_s;
  logic [7:0] isr_next_s;
  logic [2:0] lp_next_s;

  // Rank 0 is the highest priority; ranks wrap around the lowest-priority level.
  function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] lowest);
    rank_of = lvl - lowest - 3'd1;
  endfunction

  // Returns {found, level} of the highest-priority set bit under the current rotation.
  function automatic logic [3:0] highest_set(input logic [7:0] bits, input logic [2:0] lowest);
    logic [2:0] lvl;
    highest_set = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      lvl = lowest + 3'd1 + 3'(k);
      highest_set = bits[lvl] ? {1'b1, lvl} : highest_set;
    end
  endfunction

  assign fall_s      = inta_prev_r & ~interrupt_acknowledge_n;
  assign rise_s      = ~inta_prev_r & interrupt_acknowledge_n;
  assign first_ack_s = (state_r == ST_REQ) && fall_s;
  assign final_ack_s = (state_r == ST_ACK2) && rise_s;

`ifdef INTERRUPT_ACK_SEQUENCER_AUTO_EOI_EN
  assign auto_eoi_s = final_ack_s & auto_eoi_config;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = auto_eoi_config;
  assign auto_eoi_s   = 1'b0;
`endif

  // Candidate selection and nesting qualification against the ISR.
  always_comb begin
    cand_s = highest_set(interrupt_request_register & ~interrupt_mask, lowest_priority_r);
    top_s  = highest_set(in_service_register, lowest_priority_r);
    if (!cand_s[3]) begin
      qualify_s = 1'b0;
    end else if (!top_s[3]) begin
      qualify_s = 1'b1;
    end else begin
      qualify_s = rank_of(cand_s[2:0], lowest_priority_r) < rank_of(top_s[2:0], lowest_priority_r);
    end
    ack_level_s = qualify_s ? cand_s[2:0] : 3'd7;
  end

  // EOI target resolution on the pre-update ISR.
  always_comb begin
    eoi_lvl_s = 3'd0;
    eoi_hit_s = 1'b0;
    if (eoi_pulse && eoi_specific) begin
      eoi_lvl_s = eoi_level;
      eoi_hit_s = in_service_register[eoi_level];
    end else if (eoi_pulse) begin
      eoi_lvl_s = top_s[2:0];
      eoi_hit_s = top_s[3];
    end else begin
      eoi_lvl_s = 3'd0;
      eoi_hit_s = 1'b0;
    end
  end

  // Next ISR and rotation; a set from the acknowledge overrides any clear of the same bit.
  always_comb begin
    isr_clr_s = 8'd0;
    isr_set_s = 8'd0;
    lp_next_s = lowest_priority_r;
    if (eoi_hit_s) begin
      isr_clr_s = isr_clr_s | (8'd1 << eoi_lvl_s);
      lp_next_s = eoi_rotate ? eoi_lvl_s : lowest_priority_r;
    end else begin
      lp_next_s = lowest_priority_r;
    end
    if (auto_eoi_s) begin
      isr_clr_s = isr_clr_s | (8'd1 << vector_out[2:0]);
      lp_next_s = eoi_rotate ? vector_out[2:0] : lp_next_s;
    end else begin
      lp_next_s = lp_next_s;
    end
    if (first_ack_s && qualify_s) begin
      isr_set_s = 8'd1 << cand_s[2:0];
    end else begin
      isr_set_s = 8'd0;
    end
    isr_next_s = (in_service_register & ~isr_clr_s) | isr_set_s;
  end

  // Handshake FSM with all CPU- and IRR-facing outputs registered.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r                 <= ST_IDLE;
      lowest_priority_r       <= 3'd7;
      inta_prev_r             <= 1'b1;
      interrupt_to_cpu        <= 1'b0;
      freeze                  <= 1'b0;
      clear_interrupt_request <= 8'd0;
      in_service_register     <= 8'd0;
      vector_out              <= 8'd0;
      vector_valid            <= 1'b0;
    end else begin
      inta_prev_r             <= interrupt_acknowledge_n;
      in_service_register     <= isr_next_s;
      lowest_priority_r       <= lp_next_s;
      clear_interrupt_request <= 8'd0;
      case (state_r)
        ST_IDLE: begin
          if (qualify_s) begin
            interrupt_to_cpu <= 1'b1;
            state_r          <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A vanished request still completes the handshake as a spurious level 7.
          if (fall_s) begin
            clear_interrupt_request <= isr_set_s;
            freeze                  <= 1'b1;
            interrupt_to_cpu        <= 1'b0;
            vector_out              <= {vector_base, ack_level_s};
            state_r                 <= ST_ACK1;
          end
        end
        ST_ACK1: begin
          if (rise_s) begin
            state_r <= ST_WAIT2;
          end
        end
        ST_WAIT2: begin
          if (fall_s) begin
            vector_valid <= 1'b1;
            state_r      <= ST_ACK2;
          end
        end
        ST_ACK2: begin
          if (rise_s) begin
            vector_valid <= 1'b0;
            freeze       <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          interrupt_to_cpu <= 1'b0;
          freeze           <= 1'b0;
          vector_valid     <= 1'b0;
          state_r          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
